// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - row op codes, sequencer state enum and shared defaults
package tetris_pkg;

  localparam int ROWS_DEFAULT = 20;

  localparam logic [2:0] CODE_CHECK = 3'b000;
  localparam logic [2:0] CODE_MOVE  = 3'b001;
  localparam logic [2:0] CODE_WRITE = 3'b010;
  localparam logic [2:0] CODE_SHIFT = 3'b011;
  localparam logic [2:0] CODE_ADD   = 3'b100;
  localparam logic [2:0] CODE_HOLD  = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SPAWN     = 4'd1,
    ST_SPAWN_CHK = 4'd2,
    ST_WAIT      = 4'd3,
    ST_MOVE      = 4'd4,
    ST_MOVE_CHK  = 4'd5,
    ST_WRITE     = 4'd6,
    ST_CHECK     = 4'd7,
    ST_SCAN      = 4'd8,
    ST_SHIFT     = 4'd9,
    ST_OVER      = 4'd10
  } seq_state_t;

  // Row op code broadcast while the sequencer sits in a given state.
  function automatic logic [2:0] code_of(input seq_state_t s);
    case (s)
      ST_SPAWN: code_of = CODE_ADD;
      ST_MOVE:  code_of = CODE_MOVE;
      ST_WRITE: code_of = CODE_WRITE;
      ST_CHECK: code_of = CODE_CHECK;
      ST_SHIFT: code_of = CODE_SHIFT;
      default:  code_of = CODE_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// rtl/gravity_timer.sv - gravity pacing counter; SOFT_DROP_EN shortens the period while fast=1
module gravity_timer #(
  parameter int DROP_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic fast,
  output logic tick
);

  localparam int CW = (DROP_DIV > 1) ? $clog2(DROP_DIV) : 1;
  localparam logic [CW-1:0] TERM_SLOW = CW'(DROP_DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] term;

`ifdef SOFT_DROP_EN
  localparam logic [CW-1:0] TERM_FAST = CW'(DROP_DIV / 8 - 1);
  assign term = fast ? TERM_FAST : TERM_SLOW;
`else
  logic unused_fast;
  assign unused_fast = fast;
  assign term = TERM_SLOW;
`endif

  // >= rather than == so a soft drop pressed late in the period fires at once.
  assign tick = en && (cnt >= term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tetris_sequencer.sv
// rtl/tetris_sequencer.sv - game-flow controller broadcasting row op codes; optional SOFT_DROP_EN
module tetris_sequencer
  import tetris_pkg::*;
#(
  parameter int ROWS     = ROWS_DEFAULT,
  parameter int DROP_DIV = 25000000,
  parameter int LINES_W  = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop_any,
  input  logic                    endgame_any,
  input  logic [ROWS-1:0]         full_rows,
  input  logic                    drop_btn,
  output logic [2:0]              state,
  output logic [$clog2(ROWS)-1:0] clear_row_idx,
  output logic                    game_over,
  output logic [LINES_W-1:0]      lines
);

  localparam int IW = $clog2(ROWS);

  seq_state_t     fsm;
  seq_state_t     fsm_nxt;
  logic           t_clr;
  logic           t_en;
  logic           t_tick;
  logic [IW-1:0]  low_idx;

  gravity_timer #(
    .DROP_DIV (DROP_DIV)
  ) u_gravity (
    .clk   (clk),
    .reset (reset),
    .clr   (t_clr),
    .en    (t_en),
    .fast  (drop_btn),
    .tick  (t_tick)
  );

  assign t_en = (fsm == ST_WAIT);

  // Descending scan so the last hit is the lowest full row.
  always_comb begin
    low_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (full_rows[i]) low_idx = IW'(i);
    end
  end

  always_comb begin
    fsm_nxt = fsm;
    t_clr   = 1'b0;
    case (fsm)
      ST_IDLE:      if (start) fsm_nxt = ST_SPAWN;
      ST_SPAWN:     fsm_nxt = ST_SPAWN_CHK;
      ST_SPAWN_CHK: begin
        if (endgame_any) begin
          fsm_nxt = ST_OVER;
        end else begin
          t_clr   = 1'b1;
          fsm_nxt = ST_WAIT;
        end
      end
      ST_WAIT:      if (t_tick) fsm_nxt = ST_MOVE;
      ST_MOVE:      fsm_nxt = ST_MOVE_CHK;
      ST_MOVE_CHK: begin
        if (stop_any) begin
          fsm_nxt = ST_WRITE;
        end else begin
          t_clr   = 1'b1;
          fsm_nxt = ST_WAIT;
        end
      end
      ST_WRITE:     fsm_nxt = ST_CHECK;
      ST_CHECK:     fsm_nxt = ST_SCAN;
      ST_SCAN:      fsm_nxt = (full_rows == '0) ? ST_SPAWN : ST_SHIFT;
      ST_SHIFT:     fsm_nxt = ST_SCAN;
      ST_OVER:      fsm_nxt = ST_OVER;
      default:      fsm_nxt = ST_IDLE;
    endcase
  end

  // The broadcast code is registered from the next state so it lines up with fsm.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm           <= ST_IDLE;
      state         <= CODE_HOLD;
      clear_row_idx <= '0;
      game_over     <= 1'b0;
      lines         <= '0;
    end else begin
      fsm   <= fsm_nxt;
      state <= code_of(fsm_nxt);
      if (fsm == ST_SCAN && full_rows != '0) begin
        clear_row_idx <= low_idx;
        if (lines != '1) lines <= lines + LINES_W'(1);
      end
      if (fsm_nxt == ST_OVER) game_over <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tetris_sequencer.sv
// tb/tb_tetris_sequencer.sv - directed bench for tetris_sequencer; soft-drop expectations follow SOFT_DROP_EN
module tb_tetris_sequencer;

  localparam int ROWS     = 20;
  localparam int DROP_DIV = 8;
  localparam int LINES_W  = 10;

`ifdef SOFT_DROP_EN
  localparam int FAST_WAIT = 1;
  localparam int LATE_WAIT = 0;
`else
  localparam int FAST_WAIT = 8;
  localparam int LATE_WAIT = 5;
`endif

  logic               clk;
  logic               reset;
  logic               start;
  logic               stop_any;
  logic               endgame_any;
  logic [ROWS-1:0]    full_rows;
  logic               drop_btn;
  logic [2:0]         state;
  logic [4:0]         clear_row_idx;
  logic               game_over;
  logic [LINES_W-1:0] lines;

  int tests  = 0;
  int failed = 0;

  tetris_sequencer #(
    .ROWS     (ROWS),
    .DROP_DIV (DROP_DIV),
    .LINES_W  (LINES_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop_any      (stop_any),
    .endgame_any   (endgame_any),
    .full_rows     (full_rows),
    .drop_btn      (drop_btn),
    .state         (state),
    .clear_row_idx (clear_row_idx),
    .game_over     (game_over),
    .lines         (lines)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_hold(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk(tag, 32'(state), 32'h7);
    end
  endtask

  task automatic expect_code(input string tag, input logic [2:0] code);
    step();
    chk(tag, 32'(state), 32'(code));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; reset = 1'b0; start = 1'b0; stop_any = 1'b0;
    endgame_any = 1'b0; full_rows = '0; drop_btn = 1'b0;

    repeat (3) step();
    chk("reset_state", 32'(state), 32'h7);
    chk("reset_game_over", 32'(game_over), 32'h0);
    chk("reset_lines", 32'(lines), 32'h0);
    chk("reset_idx", 32'(clear_row_idx), 32'h0);
    reset = 1'b1;

    expect_hold("idle", 1);
    start = 1'b1;
    expect_code("spawn", 3'b100);
    start = 1'b0;
    expect_hold("spawn_chk", 1);

    for (int p = 0; p < 2; p++) begin
      expect_hold("gravity_wait", 8);
      expect_code("gravity_move", 3'b001);
      expect_hold("gravity_move_chk", 1);
    end

    // landing with no full rows
    expect_hold("land_wait", 8);
    expect_code("land_move", 3'b001);
    stop_any = 1'b1;
    expect_hold("land_move_chk", 1);
    expect_code("land_write", 3'b010);
    stop_any = 1'b0;
    expect_code("land_check", 3'b000);
    expect_hold("land_scan", 1);
    expect_code("land_spawn", 3'b100);

    // landing with stop+endgame together, then two full rows
    expect_hold("clr_spawn_chk", 1);
    expect_hold("clr_wait", 8);
    expect_code("clr_move", 3'b001);
    stop_any = 1'b1;
    endgame_any = 1'b1;
    expect_hold("clr_move_chk", 1);
    expect_code("clr_write_over_endgame", 3'b010);
    stop_any = 1'b0;
    endgame_any = 1'b0;
    chk("clr_no_game_over", 32'(game_over), 32'h0);
    expect_code("clr_check", 3'b000);
    full_rows = 20'h00006;
    expect_hold("clr_scan1", 1);
    chk("clr_lines0", 32'(lines), 32'h0);
    expect_code("clr_shift1", 3'b011);
    chk("clr_idx1", 32'(clear_row_idx), 32'h1);
    chk("clr_lines1", 32'(lines), 32'h1);
    full_rows = 20'h00004;
    expect_hold("clr_scan2", 1);
    expect_code("clr_shift2", 3'b011);
    chk("clr_idx2", 32'(clear_row_idx), 32'h2);
    chk("clr_lines2", 32'(lines), 32'h2);
    full_rows = '0;
    expect_hold("clr_scan3", 1);
    expect_code("clr_spawn", 3'b100);
    chk("clr_lines_final", 32'(lines), 32'h2);

    // asynchronous reset mid-WAIT
    expect_hold("rst_spawn_chk", 1);
    expect_hold("rst_wait", 3);
    #2 reset = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'h7);
    chk("async_lines", 32'(lines), 32'h0);
    chk("async_idx", 32'(clear_row_idx), 32'h0);
    step();
    reset = 1'b1;
    expect_hold("rec_idle", 1);
    start = 1'b1;
    expect_code("rec_spawn", 3'b100);
    start = 1'b0;
    expect_hold("rec_spawn_chk", 1);
    expect_hold("rec_wait", 8);
    expect_code("rec_move", 3'b001);
    expect_hold("rec_move_chk", 1);

    // game over at spawn
    reset = 1'b0;
    step();
    reset = 1'b1;
    expect_hold("go_idle", 1);
    start = 1'b1;
    expect_code("go_spawn", 3'b100);
    start = 1'b0;
    endgame_any = 1'b1;
    expect_hold("go_spawn_chk", 1);
    chk("go_not_yet", 32'(game_over), 32'h0);
    step();
    endgame_any = 1'b0;
    start = 1'b1;
    chk("go_state", 32'(state), 32'h7);
    chk("go_flag", 32'(game_over), 32'h1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("go_sticky_state", 32'(state), 32'h7);
      chk("go_sticky_flag", 32'(game_over), 32'h1);
    end
    start = 1'b0;

    // soft drop
    reset = 1'b0;
    step();
    chk("sd_reset_flag", 32'(game_over), 32'h0);
    reset = 1'b1;
    expect_hold("sd_idle", 1);
    start = 1'b1;
    expect_code("sd_spawn", 3'b100);
    start = 1'b0;
    drop_btn = 1'b1;
    expect_hold("sd_spawn_chk", 1);
    expect_hold("sd_fast_wait", FAST_WAIT);
    expect_code("sd_fast_move", 3'b001);
    expect_hold("sd_move_chk", 1);
    drop_btn = 1'b0;
    expect_hold("sd_slow_wait", 3);
    drop_btn = 1'b1;
    expect_hold("sd_late_wait", LATE_WAIT);
    expect_code("sd_late_move", 3'b001);
    drop_btn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
